// File: rtl/sample_capture_pkg.sv
// Shared definitions for the sample capture-and-dump block.
// Holds the FSM state encoding, the UART frame header byte, the datapath
// widths and the helper that picks the byte sent in each TX state.
package sample_capture_pkg;

    localparam int SAMPLE_W = 22;   // sampler word
    localparam int ADDR_W   = 23;   // SDRAM word address
    localparam int DATA_W   = 32;   // SDRAM data word
    localparam int CNT_W    = 24;   // counters must hold CAPTURE_LEN up to 2^23

    localparam logic [7:0] FRAME_HDR = 8'hAA;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CAPTURE  = 4'd1,
        S_WR_WAIT  = 4'd2,
        S_RD_ISSUE = 4'd3,
        S_RD_WAIT  = 4'd4,
        S_TX_HDR   = 4'd5,
        S_TX_B2    = 4'd6,
        S_TX_B1    = 4'd7,
        S_TX_B0    = 4'd8,
        S_TX_GAP   = 4'd9,
        S_DONE     = 4'd10
    } state_t;

    // Byte sent on the UART for a given TX state: AA, {00,d[21:16]}, d[15:8], d[7:0].
    function automatic logic [7:0] frame_byte(input state_t s, input logic [SAMPLE_W-1:0] d);
        logic [7:0] b;
        b = 8'h00;
        case (s)
            S_TX_HDR: b = FRAME_HDR;
            S_TX_B2:  b = {2'b00, d[21:16]};
            S_TX_B1:  b = d[15:8];
            S_TX_B0:  b = d[7:0];
            default:  b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sample_capture_fifo.sv
// sample_fifo: synchronous FIFO buffering sampler words between the
// sampler and the SDRAM write path.
// Ports:
//   clk100, rst      clock, asynchronous active-low reset
//   clr_i            synchronous clear of pointers and occupancy
//   push_i, data_i   write request and word
//   pop_i, data_o    read request and head-of-queue word
//   full_o, empty_o  occupancy flags
//   count_o          current occupancy (0 .. 2^FIFO_LOG2)
// A push while full is accepted only when a pop happens in the same cycle.
module sample_fifo
    import sample_capture_pkg::*;
#(
    parameter int FIFO_LOG2 = 4
) (
    input  logic                clk100,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [SAMPLE_W-1:0] data_i,
    output logic [SAMPLE_W-1:0] data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [FIFO_LOG2:0]  count_o
);

    localparam int DEPTH = 1 << FIFO_LOG2;

    logic [SAMPLE_W-1:0]  mem_q [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LOG2:0]   count_q, count_d;
    logic                 do_push, do_pop;

    assign full_o  = (count_q == DEPTH[FIFO_LOG2:0]);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + FIFO_LOG2'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + FIFO_LOG2'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (FIFO_LOG2+1)'(1);
                2'b01:   count_d = count_q - (FIFO_LOG2+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk100 or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy tracking alone decides validity.
    always_ff @(posedge clk100) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sample_capture.sv
// sample_capture: arm-triggered capture of CAPTURE_LEN sampler words into
// SDRAM, followed by a read-back dump of every word over the UART as a
// 4-byte frame (AA, {00,d[21:16]}, d[15:8], d[7:0]).
// Ports:
//   clk100, rst                      clock, asynchronous active-low reset
//   arm                              start pulse (honoured in IDLE/DONE only)
//   sample_valid, sample_data        sampler input
//   cmd_*                            SDRAM controller command interface
//   data_out, data_out_ready         SDRAM read return
//   tx_ready, tx_en, tx_byte         UART byte interface
//   busy, done, overflow             status
//
// state      | meaning
// IDLE       | waiting for arm after reset
// CAPTURE    | accepting samples, issuing a write when FIFO has data
// WR_WAIT    | write issued, waiting for controller ready again
// RD_ISSUE   | issue read of word rd_cnt
// RD_WAIT    | waiting for read data
// TX_HDR..B0 | send one frame byte when UART is ready
// TX_GAP     | one idle cycle after every byte strobe
// DONE       | dump complete, waiting for a new arm
module sample_capture
    import sample_capture_pkg::*;
#(
    parameter int                CAPTURE_LEN = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 23'd0,
    parameter int                FIFO_LOG2   = 4
) (
    input  logic                clk100,
    input  logic                rst,
    input  logic                arm,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                cmd_ready,
    output logic                cmd_enable,
    output logic                cmd_wr,
    output logic [ADDR_W-1:0]   cmd_address,
    output logic [DATA_W-1:0]   cmd_data_in,
    output logic [3:0]          cmd_byte_enable,
    input  logic [DATA_W-1:0]   data_out,
    input  logic                data_out_ready,
    input  logic                tx_ready,
    output logic                tx_en,
    output logic [7:0]          tx_byte,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CAPTURE_LEN);

    state_t              state_q, state_d;
    state_t              ret_q, ret_d;     // state to resume after TX_GAP
    logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]    rd_cnt_inc;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                overflow_q, overflow_d;

    logic                fifo_clr, fifo_push, fifo_pop;
    logic                fifo_full, fifo_empty;
    logic [SAMPLE_W-1:0] fifo_head;
    logic [FIFO_LOG2:0]  fifo_count;
    logic                accept_window;

    sample_fifo #(.FIFO_LOG2(FIFO_LOG2)) u_fifo (
        .clk100  (clk100),
        .rst     (rst),
        .clr_i   (fifo_clr),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (sample_data),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    logic unused_ok;
    assign unused_ok = &{1'b0, data_out[DATA_W-1:SAMPLE_W], fifo_count};

    assign cmd_byte_enable = 4'b1111;
    assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done            = (state_q == S_DONE);
    assign overflow        = overflow_q;
    assign rd_cnt_inc      = rd_cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        acc_cnt_d   = acc_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        sample_d    = sample_q;
        overflow_d  = overflow_q;
        fifo_clr    = 1'b0;
        fifo_pop    = 1'b0;
        fifo_push   = 1'b0;
        cmd_enable  = 1'b0;
        cmd_wr      = 1'b0;
        cmd_address = '0;
        cmd_data_in = '0;
        tx_en       = 1'b0;
        tx_byte     = 8'h00;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    fifo_clr   = 1'b1;
                    acc_cnt_d  = '0;
                    wr_cnt_d   = '0;
                    rd_cnt_d   = '0;
                    overflow_d = 1'b0;
                    state_d    = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!fifo_empty && cmd_ready) begin
                    cmd_enable  = 1'b1;
                    cmd_wr      = 1'b1;
                    cmd_address = BASE_ADDR + wr_cnt_q[ADDR_W-1:0];
                    cmd_data_in = {{(DATA_W-SAMPLE_W){1'b0}}, fifo_head};
                    fifo_pop    = 1'b1;
                    wr_cnt_d    = wr_cnt_q + CNT_W'(1);
                    state_d     = S_WR_WAIT;
                end else if (wr_cnt_q == LEN_C && fifo_empty) begin
                    rd_cnt_d = '0;
                    state_d  = S_RD_ISSUE;
                end
            end
            S_WR_WAIT: begin
                if (cmd_ready) state_d = S_CAPTURE;
            end
            S_RD_ISSUE: begin
                if (cmd_ready) begin
                    cmd_enable  = 1'b1;
                    cmd_address = BASE_ADDR + rd_cnt_q[ADDR_W-1:0];
                    state_d     = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (data_out_ready) begin
                    sample_d = data_out[SAMPLE_W-1:0];
                    state_d  = S_TX_HDR;
                end
            end
            S_TX_HDR, S_TX_B2, S_TX_B1, S_TX_B0: begin
                if (tx_ready) begin
                    tx_en   = 1'b1;
                    tx_byte = frame_byte(state_q, sample_q);
                    state_d = S_TX_GAP;
                    case (state_q)
                        S_TX_HDR: ret_d = S_TX_B2;
                        S_TX_B2:  ret_d = S_TX_B1;
                        S_TX_B1:  ret_d = S_TX_B0;
                        default: begin
                            rd_cnt_d = rd_cnt_inc;
                            ret_d    = (rd_cnt_inc < LEN_C) ? S_RD_ISSUE : S_DONE;
                        end
                    endcase
                end
            end
            S_TX_GAP: state_d = ret_q;
            default:  state_d = S_IDLE;
        endcase

        // Sample intake runs alongside the write path. A push into a full
        // FIFO still lands when the same cycle pops; otherwise it is dropped
        // and flagged without counting toward the capture length.
        accept_window = ((state_q == S_CAPTURE) || (state_q == S_WR_WAIT))
                        && sample_valid && (acc_cnt_q < LEN_C);
        if (accept_window) begin
            if (!fifo_full || fifo_pop) begin
                fifo_push = 1'b1;
                acc_cnt_d = acc_cnt_q + CNT_W'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk100 or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ret_q      <= S_IDLE;
            acc_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            sample_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            acc_cnt_q  <= acc_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            sample_q   <= sample_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture. Three instances with different
// parameters share the stimulus buses; an SDRAM/UART responder logs the
// commands and bytes of the instance selected by 'sel'.
module tb_sample_capture;

    logic        clk100;
    logic        rst;
    logic        arm [3];
    logic        sample_valid;
    logic [21:0] sample_data;
    logic        cmd_ready;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic        tx_ready;

    logic        cmd_enable_w [3];
    logic        cmd_wr_w     [3];
    logic [22:0] cmd_address_w[3];
    logic [31:0] cmd_data_w   [3];
    logic [3:0]  cmd_be_w     [3];
    logic        tx_en_w      [3];
    logic [7:0]  tx_byte_w    [3];
    logic        busy_w       [3];
    logic        done_w       [3];
    logic        overflow_w   [3];

    int total = 0;
    int bad   = 0;
    int sel   = 0;
    int viol  = 0;

    logic [22:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [22:0] rd_addr_log[$];
    logic [7:0]  tx_log[$];
    logic [31:0] mem [int];
    logic        pend;
    logic [31:0] pend_data;
    logic        prev_cmd [3];
    logic        prev_tx  [3];

    sample_capture #(.CAPTURE_LEN(4), .BASE_ADDR(23'd100), .FIFO_LOG2(4)) dut_a (
        .clk100(clk100), .rst(rst), .arm(arm[0]), .sample_valid(sample_valid),
        .sample_data(sample_data), .cmd_ready(cmd_ready), .cmd_enable(cmd_enable_w[0]),
        .cmd_wr(cmd_wr_w[0]), .cmd_address(cmd_address_w[0]), .cmd_data_in(cmd_data_w[0]),
        .cmd_byte_enable(cmd_be_w[0]), .data_out(data_out), .data_out_ready(data_out_ready),
        .tx_ready(tx_ready), .tx_en(tx_en_w[0]), .tx_byte(tx_byte_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .overflow(overflow_w[0]));

    sample_capture #(.CAPTURE_LEN(6), .BASE_ADDR(23'd0), .FIFO_LOG2(2)) dut_b (
        .clk100(clk100), .rst(rst), .arm(arm[1]), .sample_valid(sample_valid),
        .sample_data(sample_data), .cmd_ready(cmd_ready), .cmd_enable(cmd_enable_w[1]),
        .cmd_wr(cmd_wr_w[1]), .cmd_address(cmd_address_w[1]), .cmd_data_in(cmd_data_w[1]),
        .cmd_byte_enable(cmd_be_w[1]), .data_out(data_out), .data_out_ready(data_out_ready),
        .tx_ready(tx_ready), .tx_en(tx_en_w[1]), .tx_byte(tx_byte_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .overflow(overflow_w[1]));

    sample_capture #(.CAPTURE_LEN(4), .BASE_ADDR(23'h7FFFFE), .FIFO_LOG2(4)) dut_c (
        .clk100(clk100), .rst(rst), .arm(arm[2]), .sample_valid(sample_valid),
        .sample_data(sample_data), .cmd_ready(cmd_ready), .cmd_enable(cmd_enable_w[2]),
        .cmd_wr(cmd_wr_w[2]), .cmd_address(cmd_address_w[2]), .cmd_data_in(cmd_data_w[2]),
        .cmd_byte_enable(cmd_be_w[2]), .data_out(data_out), .data_out_ready(data_out_ready),
        .tx_ready(tx_ready), .tx_en(tx_en_w[2]), .tx_byte(tx_byte_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .overflow(overflow_w[2]));

    initial begin
        clk100 = 1'b0;
        forever #5 clk100 = ~clk100;
    end

    // Responder: samples DUT outputs on the falling edge. Read data returns
    // one cycle after the read strobe with junk in the unused upper bits.
    initial begin
        pend = 1'b0;
        pend_data = '0;
        data_out = '0;
        data_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            prev_cmd[i] = 1'b0;
            prev_tx[i]  = 1'b0;
        end
        forever begin
            @(negedge clk100);
            data_out_ready = pend;
            data_out       = pend ? (pend_data | 32'hFFC0_0000) : 32'h0;
            pend           = 1'b0;
            if (cmd_enable_w[sel]) begin
                if (cmd_wr_w[sel]) begin
                    wr_addr_log.push_back(cmd_address_w[sel]);
                    wr_data_log.push_back(cmd_data_w[sel]);
                    mem[int'(cmd_address_w[sel])] = cmd_data_w[sel];
                end else begin
                    rd_addr_log.push_back(cmd_address_w[sel]);
                    pend      = 1'b1;
                    pend_data = mem.exists(int'(cmd_address_w[sel])) ? mem[int'(cmd_address_w[sel])] : 32'h0;
                end
            end
            if (tx_en_w[sel]) tx_log.push_back(tx_byte_w[sel]);
            for (int i = 0; i < 3; i++) begin
                if (cmd_enable_w[i] && prev_cmd[i]) viol++;
                if (tx_en_w[i] && prev_tx[i]) viol++;
                prev_cmd[i] = cmd_enable_w[i];
                prev_tx[i]  = tx_en_w[i];
            end
        end
    end

    task automatic clear_logs();
        wr_addr_log = {};
        wr_data_log = {};
        rd_addr_log = {};
        tx_log      = {};
    endtask

    task automatic pulse_arm(input int idx);
        @(posedge clk100); #1;
        arm[idx] = 1'b1;
        @(posedge clk100); #1;
        arm[idx] = 1'b0;
    endtask

    task automatic send_sample(input logic [21:0] d);
        @(posedge clk100); #1;
        sample_valid = 1'b1;
        sample_data  = d;
        @(posedge clk100); #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_done(input int idx, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk100);
            if (done_w[idx]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk100);
        @(negedge clk100);
        total++; if (cmd_enable_w[0] !== 1'b0) begin bad++; $display("FAIL reset_cmd_enable got=%b want=0", cmd_enable_w[0]); end
        total++; if (tx_en_w[0] !== 1'b0) begin bad++; $display("FAIL reset_tx_en got=%b want=0", tx_en_w[0]); end
        total++; if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || overflow_w[0] !== 1'b0) begin
            bad++; $display("FAIL reset_status got busy=%b done=%b ovf=%b want 000", busy_w[0], done_w[0], overflow_w[0]); end
        total++; if (cmd_address_w[0] !== 23'd0 || cmd_data_w[0] !== 32'd0 || cmd_wr_w[0] !== 1'b0) begin
            bad++; $display("FAIL reset_cmd_bus got addr=%h data=%h wr=%b want 0", cmd_address_w[0], cmd_data_w[0], cmd_wr_w[0]); end
        total++; if (tx_byte_w[0] !== 8'h00) begin bad++; $display("FAIL reset_tx_byte got=%h want=00", tx_byte_w[0]); end
        total++; if (cmd_be_w[0] !== 4'hF) begin bad++; $display("FAIL byte_enable got=%h want=f", cmd_be_w[0]); end
        @(posedge clk100); #1;
        rst = 1'b1;
        repeat (3) @(negedge clk100);
        total++; if (busy_w[0] !== 1'b0 || busy_w[1] !== 1'b0) begin bad++; $display("FAIL idle_busy got a=%b b=%b want 0", busy_w[0], busy_w[1]); end
    endtask

    task automatic test_basic();
        bit ok;
        logic [7:0] got;
        logic [31:0] fr;
        sel = 0; cmd_ready = 1'b1; tx_ready = 1'b1;
        clear_logs();
        pulse_arm(0);
        @(negedge clk100);
        total++; if (busy_w[0] !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy_w[0]); end
        for (int k = 1; k <= 4; k++) send_sample(22'(k));
        wait_done(0, 2000, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_timeout got done=%b want 1", done_w[0]); end
        total++; if (wr_addr_log.size() != 4 || rd_addr_log.size() != 4) begin
            bad++; $display("FAIL basic_cmd_count got wr=%0d rd=%0d want 4 4", wr_addr_log.size(), rd_addr_log.size()); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (k >= wr_addr_log.size() || wr_addr_log[k] !== 23'(100 + k) || wr_data_log[k] !== 32'(k + 1)) begin
                bad++; $display("FAIL basic_write%0d got a=%0d d=%h want a=%0d d=%h", k,
                    (k < wr_addr_log.size()) ? wr_addr_log[k] : 23'h0, (k < wr_data_log.size()) ? wr_data_log[k] : 32'h0, 100 + k, k + 1); end
            total++;
            if (k >= rd_addr_log.size() || rd_addr_log[k] !== 23'(100 + k)) begin
                bad++; $display("FAIL basic_read%0d got=%0d want=%0d", k, (k < rd_addr_log.size()) ? rd_addr_log[k] : 23'h0, 100 + k); end
        end
        total++; if (tx_log.size() != 16) begin bad++; $display("FAIL basic_tx_count got=%0d want=16", tx_log.size()); end
        for (int k = 0; k < 16; k++) begin
            fr  = {8'hAA, 16'h0000, 8'(k / 4 + 1)};
            got = (k < tx_log.size()) ? tx_log[k] : 8'hxx;
            total++;
            if (got !== fr[31 - 8 * (k % 4) -: 8]) begin
                bad++; $display("FAIL basic_tx%0d got=%h want=%h", k, got, fr[31 - 8 * (k % 4) -: 8]); end
        end
        total++; if (done_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || overflow_w[0] !== 1'b0) begin
            bad++; $display("FAIL basic_status got done=%b busy=%b ovf=%b want 1 0 0", done_w[0], busy_w[0], overflow_w[0]); end
    endtask

    task automatic test_tx_stall();
        bit ok;
        logic [7:0] got;
        logic [31:0] fr;
        logic [21:0] smp [4];
        smp[0] = 22'h3A5C7E; smp[1] = 22'h012345; smp[2] = 22'h2ABCDE; smp[3] = 22'h000FFF;
        sel = 0; cmd_ready = 1'b1; tx_ready = 1'b1;
        clear_logs();
        pulse_arm(0);
        for (int k = 0; k < 4; k++) send_sample(smp[k]);
        send_sample(22'h3FFFFF);   // beyond CAPTURE_LEN: must be ignored
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk100);
            if (tx_log.size() == 2) begin ok = 1'b1; break; end
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_reach_b1 got bytes=%0d want 2", tx_log.size()); end
        @(posedge clk100); #1;
        tx_ready = 1'b0;
        repeat (50) @(posedge clk100);
        @(negedge clk100);
        total++; if (tx_log.size() != 2 || tx_en_w[0] !== 1'b0) begin
            bad++; $display("FAIL stall_hold got bytes=%0d tx_en=%b want 2 0", tx_log.size(), tx_en_w[0]); end
        @(posedge clk100); #1;
        tx_ready = 1'b1;
        wait_done(0, 2000, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_timeout got done=%b want 1", done_w[0]); end
        total++; if (wr_addr_log.size() != 4 || tx_log.size() != 16 || overflow_w[0] !== 1'b0) begin
            bad++; $display("FAIL stall_counts got wr=%0d tx=%0d ovf=%b want 4 16 0", wr_addr_log.size(), tx_log.size(), overflow_w[0]); end
        for (int k = 0; k < 16; k++) begin
            fr  = {8'hAA, 2'b00, smp[k / 4]};
            got = (k < tx_log.size()) ? tx_log[k] : 8'hxx;
            total++;
            if (got !== fr[31 - 8 * (k % 4) -: 8]) begin
                bad++; $display("FAIL stall_tx%0d got=%h want=%h", k, got, fr[31 - 8 * (k % 4) -: 8]); end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [31:0] exp_d [6];
        exp_d[0] = 32'h11; exp_d[1] = 32'h12; exp_d[2] = 32'h13;
        exp_d[3] = 32'h14; exp_d[4] = 32'h21; exp_d[5] = 32'h22;
        sel = 1; cmd_ready = 1'b0; tx_ready = 1'b1;
        clear_logs();
        pulse_arm(1);
        for (int k = 0; k < 6; k++) send_sample(22'(8'h11 + k));
        @(negedge clk100);
        total++; if (overflow_w[1] !== 1'b1 || wr_addr_log.size() != 0) begin
            bad++; $display("FAIL ovf_set got ovf=%b writes=%0d want 1 0", overflow_w[1], wr_addr_log.size()); end
        pulse_arm(1);   // ignored while capturing
        @(negedge clk100);
        total++; if (overflow_w[1] !== 1'b1 || busy_w[1] !== 1'b1) begin
            bad++; $display("FAIL ovf_arm_ignored got ovf=%b busy=%b want 1 1", overflow_w[1], busy_w[1]); end
        // Push into the full FIFO in the same cycle as the first pop.
        @(posedge clk100); #1;
        cmd_ready    = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 22'h21;
        @(posedge clk100); #1;
        sample_valid = 1'b0;
        send_sample(22'h22);
        wait_done(1, 2000, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL ovf_timeout got done=%b want 1", done_w[1]); end
        total++; if (wr_addr_log.size() != 6 || tx_log.size() != 24 || overflow_w[1] !== 1'b1) begin
            bad++; $display("FAIL ovf_counts got wr=%0d tx=%0d ovf=%b want 6 24 1", wr_addr_log.size(), tx_log.size(), overflow_w[1]); end
        for (int k = 0; k < 6; k++) begin
            total++;
            if (k >= wr_addr_log.size() || wr_addr_log[k] !== 23'(k) || wr_data_log[k] !== exp_d[k]) begin
                bad++; $display("FAIL ovf_write%0d got a=%0d d=%h want a=%0d d=%h", k,
                    (k < wr_addr_log.size()) ? wr_addr_log[k] : 23'h0, (k < wr_data_log.size()) ? wr_data_log[k] : 32'h0, k, exp_d[k]); end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [22:0] exp_a [4];
        exp_a[0] = 23'h7FFFFE; exp_a[1] = 23'h7FFFFF; exp_a[2] = 23'h000000; exp_a[3] = 23'h000001;
        sel = 2; cmd_ready = 1'b1; tx_ready = 1'b1;
        clear_logs();
        pulse_arm(2);
        for (int k = 0; k < 4; k++) send_sample(22'(8'h0A + k));
        wait_done(2, 2000, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL wrap_timeout got done=%b want 1", done_w[2]); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (k >= wr_addr_log.size() || k >= rd_addr_log.size() || wr_addr_log[k] !== exp_a[k] || rd_addr_log[k] !== exp_a[k]) begin
                bad++; $display("FAIL wrap_addr%0d got wr=%h rd=%h want %h", k,
                    (k < wr_addr_log.size()) ? wr_addr_log[k] : 23'h0, (k < rd_addr_log.size()) ? rd_addr_log[k] : 23'h0, exp_a[k]); end
            total++;
            if (4 * k + 3 >= tx_log.size() || tx_log[4 * k + 3] !== 8'(8'h0A + k)) begin
                bad++; $display("FAIL wrap_data%0d got=%h want=%h", k, (4 * k + 3 < tx_log.size()) ? tx_log[4 * k + 3] : 8'h00, 8'h0A + k); end
        end
    endtask

    task automatic test_reset_midrun();
        bit ok;
        sel = 0; cmd_ready = 1'b1; tx_ready = 1'b1;
        clear_logs();
        pulse_arm(0);
        for (int k = 0; k < 4; k++) send_sample(22'(5 + k));
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk100);
            if (rd_addr_log.size() == 1) begin ok = 1'b1; break; end
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL midrst_reach_rd got reads=%0d want 1", rd_addr_log.size()); end
        @(posedge clk100); #1;   // now in RD_WAIT
        rst = 1'b0;
        @(negedge clk100);
        total++; if (cmd_enable_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || tx_en_w[0] !== 1'b0) begin
            bad++; $display("FAIL midrst_outputs got cmd=%b busy=%b tx=%b want 0 0 0", cmd_enable_w[0], busy_w[0], tx_en_w[0]); end
        @(posedge clk100); #1;
        rst = 1'b1;
        repeat (40) @(negedge clk100);
        total++; if (tx_log.size() != 0 || rd_addr_log.size() != 1 || wr_addr_log.size() != 4) begin
            bad++; $display("FAIL midrst_quiet got tx=%0d rd=%0d wr=%0d want 0 1 4", tx_log.size(), rd_addr_log.size(), wr_addr_log.size()); end
        clear_logs();
        pulse_arm(0);
        for (int k = 0; k < 4; k++) send_sample(22'(9 + k));
        wait_done(0, 2000, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL midrst_rerun_timeout got done=%b want 1", done_w[0]); end
        total++; if (wr_addr_log.size() < 1 || wr_addr_log[0] !== 23'd100 || tx_log.size() != 16) begin
            bad++; $display("FAIL midrst_rerun got first_addr=%0d tx=%0d want 100 16",
                (wr_addr_log.size() > 0) ? wr_addr_log[0] : 23'h0, tx_log.size()); end
    endtask

    task automatic test_strobe_width();
        total++; if (viol != 0) begin bad++; $display("FAIL strobe_width got violations=%0d want 0", viol); end
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 3; i++) arm[i] = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        cmd_ready    = 1'b1;
        tx_ready     = 1'b1;
        test_reset();
        test_basic();
        test_tx_stall();
        test_overflow();
        test_wrap();
        test_reset_midrun();
        test_strobe_width();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_capture.md
SAMPLE_CAPTURE -- requirements
Module: sample_capture

Interface
REQ-001 Parameter CAPTURE_LEN, default 1024, samples per capture (1..2^23).
REQ-002 Parameter BASE_ADDR, default 23'd0, first SDRAM word address.
REQ-003 Parameter FIFO_LOG2, default 4, FIFO depth 2^FIFO_LOG2 entries.
REQ-004 clk100  in  1  system clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 arm  in  1  one-cycle pulse that starts a capture-and-dump run.
REQ-007 sample_valid  in  1  one-cycle pulse, sample_data valid.
REQ-008 sample_data  in  22  sampler word, bits [11:0] are the ADC code.
REQ-009 cmd_ready  in  1  SDRAM controller can accept a command.
REQ-010 cmd_enable  out  1  command strobe to the controller.
REQ-011 cmd_wr  out  1  1 = write, 0 = read.
REQ-012 cmd_address  out  23  SDRAM word address.
REQ-013 cmd_data_in  out  32  write data.
REQ-014 cmd_byte_enable  out  4  constant 4'b1111.
REQ-015 data_out  in  32  read data from the controller.
REQ-016 data_out_ready  in  1  one-cycle pulse, data_out valid.
REQ-017 tx_ready  in  1  UART can accept a byte.
REQ-018 tx_en  out  1  one-cycle byte strobe to the UART.
REQ-019 tx_byte  out  8  byte to transmit.
REQ-020 busy  out  1  high in any state other than IDLE and DONE.
REQ-021 done  out  1  high in DONE.
REQ-022 overflow  out  1  sticky: at least one sample was dropped.

Function
REQ-023 The FSM SHALL have states IDLE, CAPTURE, WR_WAIT, RD_ISSUE, RD_WAIT, TX_HDR, TX_B2, TX_B1, TX_B0, TX_GAP and DONE.
REQ-024 In IDLE or DONE, an arm pulse SHALL clear overflow, both counters and the FIFO, and move to CAPTURE. In any other state, arm SHALL be ignored.
REQ-025 In CAPTURE, each sample_valid SHALL push sample_data into the FIFO until CAPTURE_LEN samples have been accepted. Later pulses SHALL be ignored and SHALL not set overflow.
REQ-026 If sample_valid arrives while the FIFO is full, the sample SHALL be dropped, overflow SHALL be set, and the drop SHALL not count toward CAPTURE_LEN.
REQ-027 When the FIFO is non-empty and cmd_ready=1, the block SHALL assert cmd_enable=1 and cmd_wr=1 for exactly one cycle, with cmd_address=BASE_ADDR+wr_cnt and cmd_data_in={10'b0, FIFO head}. It SHALL pop the FIFO and go to WR_WAIT.
REQ-028 WR_WAIT SHALL last at least one cycle, then return to CAPTURE on cmd_ready=1. Pushes SHALL continue during WR_WAIT.
REQ-029 When wr_cnt reaches CAPTURE_LEN and the FIFO is empty, the FSM SHALL go to RD_ISSUE with rd_cnt=0.
REQ-030 In RD_ISSUE, on cmd_ready=1 the block SHALL pulse cmd_enable for one cycle with cmd_wr=0 and cmd_address=BASE_ADDR+rd_cnt, then go to RD_WAIT.
REQ-031 RD_WAIT SHALL latch data_out[21:0] on data_out_ready and go to TX_HDR. Any data_out_ready outside RD_WAIT SHALL be ignored.
REQ-032 Each sample SHALL be sent as the frame 8'hAA, {2'b00, d[21:16]}, d[15:8], d[7:0], in states TX_HDR, TX_B2, TX_B1, TX_B0.
REQ-033 In each TX state, tx_en SHALL pulse for one cycle when tx_ready=1. Each pulse SHALL be followed by a TX_GAP cycle with tx_en=0 before tx_ready is sampled again.
REQ-034 After TX_B0, rd_cnt SHALL increment. The FSM SHALL return to RD_ISSUE if rd_cnt<CAPTURE_LEN, otherwise go to DONE.
REQ-035 Address arithmetic SHALL be 23-bit modulo 2^23, so BASE_ADDR+CAPTURE_LEN past 2^23-1 wraps to 0.
REQ-036 A simultaneous push and pop on the FIFO SHALL leave its occupancy unchanged, and is legal when the FIFO is full.
REQ-037 cmd_enable and tx_en SHALL never be high for more than one consecutive cycle.

Reset
REQ-038 On rst=0, the block SHALL immediately force state IDLE, cmd_enable=0, tx_en=0, busy=0, done=0 and overflow=0. It SHALL also clear cmd_wr, cmd_address, cmd_data_in, tx_byte, the counters and the FIFO pointers to 0.
REQ-039 Reset asserted mid-run SHALL abandon the run, with no further commands or bytes issued. Reset release SHALL take effect on the next clk100 edge.

Structure
REQ-040 A shared package SHALL hold the state encoding, the frame header constant 8'hAA, and the widths 22, 23 and 32.
REQ-041 The FIFO SHALL be a sub-module sample_fifo (width 22, depth 2^FIFO_LOG2, with full, empty and count outputs).

Verification
REQ-042 CAPTURE_LEN=4, BASE_ADDR=100, samples 0x000001..0x000004 with cmd_ready always 1 -> writes to addresses 100..103, reads from 100..103, UART bytes AA 00 00 01 ... AA 00 00 04, then done=1.
REQ-043 FIFO_LOG2=2, cmd_ready held 0, 6 sample_valid pulses -> 4 samples stored, overflow=1, and the next 2 accepted samples fill the capture.
REQ-044 tx_ready held low for 50 cycles during TX_B1 -> tx_en stays 0, and the byte order is preserved after release.
REQ-045 BASE_ADDR=23'h7FFFFE, CAPTURE_LEN=4 -> addresses 7FFFFE, 7FFFFF, 000000, 000001.
REQ-046 rst pulsed during RD_WAIT -> next cycle cmd_enable=0, busy=0, and no tx_en afterwards. A following arm restarts writes at BASE_ADDR.
REQ-047 arm pulsed during CAPTURE -> ignored, with the counters and overflow unchanged.
